// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported unified memory between the instruction
//            fetch requester (read-only) and the data requester (read/write).
//            One transaction in flight, fixed memory read latency, data side
//            has priority, and fetch is protected by an anti-starvation count.
// Ports    : clk, reset (sync, active-low)
//            i_req/i_addr -> i_gnt, i_rvalid, i_rdata      (fetch side)
//            d_req/d_we/d_be/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata
//            mem_en/mem_we/mem_be/mem_addr/mem_wdata, mem_rdata (memory)
//            busy : a transaction is in flight
// Options  : `define MEM_PORT_ARBITER_STATS_EN adds conflict_cnt and
//            i_stall_cnt statistic outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int MEM_LAT    = 1,  // read latency, 1..7
   parameter int STARVE_MAX = 3   // max data grants while fetch waits, 1..15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
`ifdef MEM_PORT_ARBITER_STATS_EN
   ,
   output logic [31:0] conflict_cnt,
   output logic [31:0] i_stall_cnt
`endif
);

   localparam logic [2:0] LAT_DONE     = 3'(MEM_LAT);
   localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        owner_q, owner_d;        // 1 = data side, 0 = fetch side
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;

   logic wr_done;
   logic rd_done;
   logic accept;
   logic i_pri;

   // A write finishes in its issue cycle; a read finishes in the wait cycle
   // where the memory data lands. Either frees the port for a new grant.
   assign wr_done = (state_q == ST_ISSUE) && owner_q && we_q;
   assign rd_done = (state_q == ST_WAIT) && (lat_cnt_q == LAT_DONE);
   assign accept  = reset && ((state_q == ST_IDLE) || wr_done || rd_done);
   assign i_pri   = (starve_cnt_q == STARVE_LIMIT);

   assign i_gnt = accept && i_req && (!d_req || i_pri);
   assign d_gnt = accept && d_req && !(i_req && i_pri);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      be_d         = be_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;

      case (state_q)
         ST_ISSUE: begin
            if (wr_done) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_WAIT;
               lat_cnt_d = 3'd1;
            end
         end
         ST_WAIT: begin
            if (rd_done) begin
               state_d = ST_IDLE;
            end else begin
               lat_cnt_d = 3'(lat_cnt_q + 3'd1);
            end
         end
         default: ;
      endcase

      // A grant in a done cycle overrides the return to IDLE, giving
      // back-to-back issue with no bubble.
      if (d_gnt) begin
         state_d = ST_ISSUE;
         owner_d = 1'b1;
         we_d    = d_we;
         be_d    = d_be;
         addr_d  = d_addr;
         wdata_d = d_wdata;
      end else if (i_gnt) begin
         state_d = ST_ISSUE;
         owner_d = 1'b0;
         we_d    = 1'b0;
         be_d    = 4'hF;
         addr_d  = i_addr;
         wdata_d = 32'd0;
      end

      // Count data grants that overtook a waiting fetch.
      if (!i_req || i_gnt) begin
         starve_cnt_d = 4'd0;
      end else if (d_gnt && (starve_cnt_q < STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         be_q         <= 4'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         lat_cnt_q    <= 3'd0;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         be_q         <= be_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Memory strobes come straight from the latched request fields and are
   // forced to zero whenever no access is being issued.
   assign mem_en    = (state_q == ST_ISSUE);
   assign mem_we    = mem_en && we_q;
   assign mem_be    = mem_en ? be_q    : 4'd0;
   assign mem_addr  = mem_en ? addr_q  : 32'd0;
   assign mem_wdata = mem_en ? wdata_q : 32'd0;

   assign i_rvalid  = rd_done && !owner_q;
   assign i_rdata   = i_rvalid ? mem_rdata : 32'd0;
   assign d_rvalid  = wr_done || (rd_done && owner_q);
   assign d_rdata   = (rd_done && owner_q) ? mem_rdata : 32'd0;

   assign busy      = (state_q != ST_IDLE);

`ifdef MEM_PORT_ARBITER_STATS_EN
   logic [31:0] conflict_cnt_q;
   logic [31:0] i_stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         conflict_cnt_q <= 32'd0;
         i_stall_cnt_q  <= 32'd0;
      end else begin
         if (accept && i_req && d_req) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
         end
         if (i_req && !i_gnt) begin
            i_stall_cnt_q <= i_stall_cnt_q + 32'd1;
         end
      end
   end

   assign conflict_cnt = conflict_cnt_q;
   assign i_stall_cnt  = i_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter (MEM_LAT=2,
//            STARVE_MAX=3) with a small pipelined memory model whose read
//            data is {addr[15:0], ~addr[15:0]}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
`ifdef MEM_PORT_ARBITER_STATS_EN
   logic [31:0] conflict_cnt;
   logic [31:0] i_stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_rvalid  (i_rvalid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
`ifdef MEM_PORT_ARBITER_STATS_EN
      ,
      .conflict_cnt (conflict_cnt),
      .i_stall_cnt  (i_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: read data appears LAT cycles after the mem_en cycle.
   logic [31:0] pipe [LAT];
   initial for (int k = 0; k < LAT; k++) pipe[k] = 32'd0;
   always @(posedge clk) begin
      pipe[0] <= (mem_en && !mem_we) ? {mem_addr[15:0], ~mem_addr[15:0]} : 32'd0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign mem_rdata = pipe[LAT-1];

   // Inputs change at negedge; outputs are sampled 2 time units later.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; i_req = 1'b0; i_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
      repeat (3) tick();
      #2;
      checks++;
      if ({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy} !== 7'd0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy});
      end
      checks++;
      if ((i_rdata | d_rdata | mem_addr | mem_wdata | {28'd0, mem_be}) !== 32'd0) begin
         failures++;
         $display("FAIL reset_data: got or-of-buses %h want 0",
                  i_rdata | d_rdata | mem_addr | mem_wdata | {28'd0, mem_be});
      end
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      logic exp_gnt  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic exp_en   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic exp_rv   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic exp_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 5; c++) begin
         if (c == 0) begin i_req = 1'b1; i_addr = 32'h0000_0100; end
         else i_req = 1'b0;
         #2;
         checks++;
         if ({i_gnt, mem_en, i_rvalid, busy, d_gnt} !==
             {exp_gnt[c], exp_en[c], exp_rv[c], exp_busy[c], 1'b0}) begin
            failures++;
            $display("FAIL fetch_cycle%0d: gnt/en/rvalid/busy/dgnt got %b want %b", c,
                     {i_gnt, mem_en, i_rvalid, busy, d_gnt},
                     {exp_gnt[c], exp_en[c], exp_rv[c], exp_busy[c], 1'b0});
         end
         if (c == 1) begin
            checks++;
            if (mem_addr !== 32'h0000_0100 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
               failures++;
               $display("FAIL fetch_issue: addr=%h we=%b be=%h want 00000100 0 f",
                        mem_addr, mem_we, mem_be);
            end
         end
         if (c == 3) begin
            checks++;
            if (i_rdata !== 32'h0100_FEFF) begin
               failures++;
               $display("FAIL fetch_rdata: got %h want 0100feff", i_rdata);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 4; c++) begin
         d_req = (c < 2); d_we = 1'b1; d_be = 4'hF;
         d_addr  = (c == 0) ? 32'h0000_0200 : 32'h0000_0204;
         d_wdata = (c == 0) ? 32'h1111_1111 : 32'h2222_2222;
         #2;
         checks++;
         if ({d_gnt, mem_en, d_rvalid, busy} !==
             {(c < 2), (c == 1 || c == 2), (c == 1 || c == 2), (c == 1 || c == 2)}) begin
            failures++;
            $display("FAIL wr_cycle%0d: gnt/en/rvalid/busy got %b want %b", c,
                     {d_gnt, mem_en, d_rvalid, busy},
                     {(c < 2), (c == 1 || c == 2), (c == 1 || c == 2), (c == 1 || c == 2)});
         end
         if (c == 1 || c == 2) begin
            checks++;
            if (mem_addr !== ((c == 1) ? 32'h0000_0200 : 32'h0000_0204) ||
                mem_wdata !== ((c == 1) ? 32'h1111_1111 : 32'h2222_2222) ||
                mem_we !== 1'b1 || mem_be !== 4'hF || d_rdata !== 32'd0) begin
               failures++;
               $display("FAIL wr_issue%0d: addr=%h wdata=%h we=%b be=%h rdata=%h", c,
                        mem_addr, mem_wdata, mem_we, mem_be, d_rdata);
            end
         end
         tick();
      end
      d_we = 1'b0;
   endtask

   task automatic test_starvation();
      logic [7:0] exp_i = 8'b1000_1000;   // grant k is a fetch grant when bit k set
      int ng = 0;
      int cyc = 0;
      int last = -10;
      int n = 0;
      i_req = 1'b1; i_addr = 32'h0000_0300;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0400; d_wdata = 32'd0;
      while (ng < 8 && cyc < 40) begin
         #2;
         if (i_gnt && d_gnt) begin
            checks++; failures++;
            $display("FAIL dual_grant: cycle %0d both grants high", cyc);
         end
         if (cyc == last + 1) begin
            checks++;
            if (mem_en !== 1'b1) begin
               failures++;
               $display("FAIL no_bubble: cycle %0d mem_en=%b want 1", cyc, mem_en);
            end
         end
         if (i_gnt || d_gnt) begin
            checks++;
            if (i_gnt !== exp_i[ng] || cyc != ng * 3) begin
               failures++;
               $display("FAIL starve_order%0d: i_gnt=%b at cycle %0d want i_gnt=%b at %0d",
                        ng, i_gnt, cyc, exp_i[ng], ng * 3);
            end
            if (ng > 0) begin
               checks++;
               if (exp_i[ng-1] ? (i_rvalid !== 1'b1 || i_rdata !== 32'h0300_FCFF)
                               : (d_rvalid !== 1'b1 || d_rdata !== 32'h0400_FBFF)) begin
                  failures++;
                  $display("FAIL resp%0d: i_rv=%b i_rd=%h d_rv=%b d_rd=%h", ng - 1,
                           i_rvalid, i_rdata, d_rvalid, d_rdata);
               end
            end
            last = cyc;
            ng++;
         end
         cyc++;
         tick();
      end
      if (ng < 8) begin
         checks++; failures++;
         $display("FAIL starve_timeout: got %0d grants want 8", ng);
      end
      i_req = 1'b0; d_req = 1'b0;
      while (busy === 1'b1 && n < 20) begin tick(); n++; end
      if (n >= 20) begin
         checks++; failures++;
         $display("FAIL starve_drain: busy=%b want 0", busy);
      end
      tick();
   endtask

   task automatic test_reset_in_wait();
      logic seen_rv = 1'b0;
      int   n       = 0;
      i_req = 1'b1; i_addr = 32'h0000_0500;
      #2;
      checks++;
      if (i_gnt !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre_gnt: got %b want 1", i_gnt);
      end
      tick(); i_req = 1'b0;            // ISSUE
      tick(); reset = 1'b0;            // first WAIT cycle: reset sampled here
      tick();                          // reset still low
      #2;
      checks++;
      if ({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy} !== 7'd0 ||
          mem_addr !== 32'd0 || i_rdata !== 32'd0) begin
         failures++;
         $display("FAIL rst_outputs: ctrl=%b addr=%h rdata=%h want 0",
                  {i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, mem_addr, i_rdata);
      end
      if (i_rvalid === 1'b1) seen_rv = 1'b1;
      tick(); reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #2;
         if (i_rvalid === 1'b1 || busy === 1'b1) seen_rv = 1'b1;
         tick();
      end
      checks++;
      if (seen_rv) begin
         failures++;
         $display("FAIL rst_dropped: stale rvalid or busy got 1 want 0");
      end
      i_req = 1'b1; i_addr = 32'h0000_0600;
      #2;
      checks++;
      if (i_gnt !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_fresh_gnt: gnt=%b busy=%b want 1 0", i_gnt, busy);
      end
      tick(); i_req = 1'b0;
      tick(); tick();
      #2;
      checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'h0600_F9FF) begin
         failures++;
         $display("FAIL rst_fresh_data: rvalid=%b rdata=%h want 1 0600f9ff", i_rvalid, i_rdata);
      end
      while (busy === 1'b1 && n < 20) begin tick(); n++; end
      tick();
   endtask

`ifdef MEM_PORT_ARBITER_STATS_EN
   task automatic test_stats();
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      // Both requesters wait from cycle 0: grants D,D,D at 0/3/6, I at 9.
      i_req = 1'b1; i_addr = 32'h0000_0700;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0800;
      for (int c = 0; c < 10; c++) tick();
      i_req = 1'b0; d_req = 1'b0;
      repeat (6) tick();
      #2;
      checks++;
      if (conflict_cnt !== 32'd4) begin
         failures++;
         $display("FAIL stats_conflict: got %0d want 4", conflict_cnt);
      end
      checks++;
      if (i_stall_cnt !== 32'd9) begin
         failures++;
         $display("FAIL stats_stall: got %0d want 9", i_stall_cnt);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_starvation();
      test_reset_in_wait();
`ifdef MEM_PORT_ARBITER_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
